// File: rtl/aes_inv_round_sched.sv
// aes_inv_round_sched
// Iterative AES inverse cipher: a single shared round datapath
// (InvMixColumns -> InvShiftRows -> InvSubBytes -> AddRoundKey) is reused once
// per clock, sequenced by a round counter and a three-state FSM.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   ciphertext + expanded key + size accept (IDLE only)
//   in_data [127:0]       ciphertext block
//   key_out [KW-1:0]      expanded key bus, round key i at [128*(i+1)-1:128*i]
//   size [1:0]            00 AES-128, 01 AES-192, 10/11 unsupported
//   out_valid / out_ready plaintext handshake
//   out_data [127:0]      plaintext (0 for unsupported size)
//   out_err               unsupported size code, qualified by out_valid
//   busy                  engine in RUN or DONE
module aes_inv_round_sched #(
    parameter int NR_MAX = 12,
    parameter int KW     = 128 * (NR_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic [KW-1:0] key_out,
    input  logic [1:0]    size,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          out_err,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    // Byte 0 of a block is its most significant byte; byte (r + 4c) is row r, column c.
    typedef logic [0:15][7:0] blk_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (enough for 09/0b/0d/0e).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[4*c]   = gmul(s[4*c], 4'he) ^ gmul(s[4*c+1], 4'hb) ^ gmul(s[4*c+2], 4'hd) ^ gmul(s[4*c+3], 4'h9);
            o[4*c+1] = gmul(s[4*c], 4'h9) ^ gmul(s[4*c+1], 4'he) ^ gmul(s[4*c+2], 4'hb) ^ gmul(s[4*c+3], 4'hd);
            o[4*c+2] = gmul(s[4*c], 4'hd) ^ gmul(s[4*c+1], 4'h9) ^ gmul(s[4*c+2], 4'he) ^ gmul(s[4*c+3], 4'hb);
            o[4*c+3] = gmul(s[4*c], 4'hb) ^ gmul(s[4*c+1], 4'hd) ^ gmul(s[4*c+2], 4'h9) ^ gmul(s[4*c+3], 4'he);
        end
        return o;
    endfunction

    // InvShiftRows (row r rotated right by r) fused with InvSubBytes.
    function automatic blk_t inv_shift_sub(input blk_t s);
        blk_t o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r+4*c] = INV_SBOX[s[r+4*((c+4-r)%4)]];
            end
        end
        return o;
    endfunction

    state_e                  st_q, st_d;
    blk_t                    s_q, s_d;
    logic [NR_MAX:0][127:0]  key_q, key_d;
    logic [NR_MAX:0][127:0]  key_in;
    logic [3:0]              nr_q, nr_d;
    logic [3:0]              rnd_q, rnd_d;
    logic                    err_q, err_d;
    logic [127:0]            out_q, out_d;
    logic                    ov_q, ov_d;
    logic [3:0]              kidx;
    blk_t                    t;

    assign key_in = key_out;

    always_comb begin
        st_d  = st_q;
        s_d   = s_q;
        key_d = key_q;
        nr_d  = nr_q;
        rnd_d = rnd_q;
        err_d = err_q;
        out_d = out_q;
        ov_d  = ov_q;
        kidx  = nr_q - 4'd1 - rnd_q;
        t     = (rnd_q == 4'd0) ? s_q : inv_mix_columns(s_q);
        case (st_q)
            IDLE: begin
                ov_d = 1'b0;
                if (in_valid) begin
                    key_d = key_in;
                    if (!size[1]) begin
                        nr_d  = size[0] ? 4'd12 : 4'd10;
                        s_d   = in_data ^ key_in[nr_d];
                        rnd_d = 4'd0;
                        err_d = 1'b0;
                        st_d  = RUN;
                    end else begin
                        // Unsupported size: skip RUN; out_valid follows one cycle later.
                        out_d = '0;
                        err_d = 1'b1;
                        st_d  = DONE;
                    end
                end
            end
            RUN: begin
                s_d   = inv_shift_sub(t) ^ key_q[kidx];
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == nr_q - 4'd1) begin
                    out_d = s_d;
                    err_d = 1'b0;
                    ov_d  = 1'b1;
                    rnd_d = 4'd0;
                    st_d  = DONE;
                end
            end
            DONE: begin
                if (!ov_q) begin
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d  = 1'b0;
                    err_d = 1'b0;
                    st_d  = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            s_q   <= '0;
            key_q <= '0;
            nr_q  <= '0;
            rnd_q <= '0;
            err_q <= 1'b0;
            out_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            st_q  <= st_d;
            s_q   <= s_d;
            key_q <= key_d;
            nr_q  <= nr_d;
            rnd_q <= rnd_d;
            err_q <= err_d;
            out_q <= out_d;
            ov_q  <= ov_d;
        end
    end

    assign in_ready  = (st_q == IDLE);
    assign busy      = (st_q != IDLE);
    assign out_valid = ov_q;
    assign out_data  = out_q;
    assign out_err   = err_q;

endmodule

// File: doc/aes_inv_round_sched.md
Name: aes_inv_round_sched

Overview:
- Iterative AES inverse-cipher engine that processes one round per clock.
- Holds a single shared round datapath (InvMixColumns, InvShiftRows, InvSubBytes, InvAddRoundKey instances) and sequences it with a round counter and FSM.
- Captures ciphertext, the expanded key bus and the size code on a valid/ready accept, then presents plaintext on a valid/ready output.
- Area-reduced alternative to the fully unrolled inverse cipher. Uses the same key-bus layout and size encoding.

Parameters:
- NR_MAX, 12, maximum supported round count. Key bus carries NR_MAX+1 round keys.
- KW, 128*(NR_MAX+1), expanded-key bus width in bits (1664).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  ciphertext/key/size offered
- in_ready  output  1  engine can accept (IDLE only)
- in_data  input  128  ciphertext block
- key_out  input  KW  expanded round keys; round key i = bits [128*(i+1)-1 : 128*i]
- size  input  2  00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10/11 = unsupported
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- out_data  output  128  plaintext
- out_err  output  1  result is from an unsupported size code; qualified by out_valid
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_err=0, busy=0, out_data=0, round counter=0.
  - Reset mid-RUN or mid-DONE discards the block with no output.
- Registers:
  - state (128b), key register (KW bits), Nr (4b), rnd (4b), err (1b).
- IDLE:
  - in_ready=1.
  - On accept (in_valid & in_ready), latch key_out and size.
  - For size 00/01:
    - Nr = 10 or 12.
    - state <= in_data ^ key[Nr] (initial AddRoundKey).
    - rnd <= 0.
    - Go to RUN.
  - For size 10/11:
    - out_data <= 0, err <= 1.
    - Go directly to DONE. out_valid rises the next cycle.
- RUN (one round step per cycle, j = rnd):
  - t = (j==0) ? state : InvMixColumns(state).
  - state <= InvSubBytes(InvShiftRows(t)) ^ key[Nr-1-j].
  - rnd <= rnd+1.
  - After the step with j = Nr-1: out_data <= the new state, err <= 0, go to DONE.
  - in_data, key_out and size changes during RUN are ignored; all three were captured at accept.
- DONE:
  - out_valid=1.
  - out_data and out_err are held stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so no accept can happen in the same cycle as an output handshake.
- Latency:
  - Accept at edge T → out_valid high after edge T+Nr. That is 10 cycles for AES-128 and 12 for AES-192.
  - Invalid size: out_valid high after edge T+1.
  - Minimum issue interval is Nr+2 cycles with out_ready held at 1.
- Size and keys:
  - size is sampled only at accept.
  - Only key[0..Nr] are used. Unused upper key slices are don't-care.
- Key indexing: key index Nr-1-j is always in range 0..Nr-1. rnd never exceeds Nr-1 in RUN.
- Back-pressure: out_ready=0 holds DONE indefinitely with no state change.
- All outputs are registered or decoded directly from the FSM state. There is no combinational path from inputs to outputs.

Test Plan:
- AES-128 known-answer (FIPS-197 C.1):
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, bench-expanded key schedule; in_data 69c4e0d86a7b0430d8cdb78070b4c55a; size=00.
  - Required: out_data 00112233445566778899aabbccddeeff, out_err=0, out_valid high exactly 10 cycles after accept.
- AES-192 known-answer (FIPS-197 C.2):
  - Stimulus: key 000102…1617; in_data dda97ca4864cdfe06eaf70a0ec0d7191; size=01; key slices 13+ randomised.
  - Required: out_data 00112233445566778899aabbccddeeff, out_valid 12 cycles after accept.
- Unsupported size:
  - Stimulus: size=10, then separately size=11.
  - Required: out_valid one cycle after accept, out_data=0, out_err=1, no RUN cycles (busy high for exactly one cycle before out_valid).
- Back-pressure and input isolation:
  - Stimulus: hold out_ready=0 for 20 cycles after completion; toggle in_data, key_out and size randomly throughout RUN and DONE.
  - Required: out_data stable and correct, in_ready=0 throughout, result matches the values captured at accept.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle at RUN step 5.
  - Required: next cycle IDLE with in_ready=1, out_valid=0, out_data=0. A following C.1 block decrypts correctly with nominal latency.
- Back-to-back throughput:
  - Stimulus: 8 random AES-128/AES-192 blocks, in_valid and out_ready held high.
  - Required: all outputs match the reference model in order, accept spacing of Nr+2 cycles.
